// File: rtl/pipe_scoreboard_pkg.sv
// rtl/pipe_scoreboard_pkg.sv - shared types and constants for the pipeline hazard scoreboard
package pipe_scoreboard_pkg;

  localparam int REG_ADDR_W_DEF = 5;
  // Slot rd field is sized for the widest legal register index; narrower indices are zero-extended.
  localparam int RD_W_MAX = 8;
  // Forward select value meaning "take the operand from the register file".
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                valid;
    logic [RD_W_MAX-1:0] rd;
    logic                is_load;
  } slot_t;

  function automatic int sel_w(input int num_stages);
    return $clog2(num_stages + 1);
  endfunction

endpackage

// File: rtl/pipe_scoreboard_sb_match.sv
// rtl/pipe_scoreboard_sb_match.sv - youngest-producer priority matcher for one source operand
module sb_match
  import pipe_scoreboard_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int M_W        = 2
) (
  input  slot_t [NUM_STAGES-1:0] slots_i,
  input  logic  [RD_W_MAX-1:0]   rs_i,
  input  logic                   en_i,
  output logic                   hit_o,
  output logic  [M_W-1:0]        m_o,
  output logic                   is_load_o
);

  // Scan oldest to youngest so the lowest matching slot index is the one left standing.
  always_comb begin
    hit_o     = 1'b0;
    m_o       = '0;
    is_load_o = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (en_i && slots_i[k].valid && (slots_i[k].rd == rs_i)) begin
        hit_o     = 1'b1;
        m_o       = M_W'(k);
        is_load_o = slots_i[k].is_load;
      end
    end
  end

endmodule

// File: rtl/pipe_scoreboard.sv
// rtl/pipe_scoreboard.sv - in-flight write tracker producing ID stall, forward selects and perf counters
module pipe_scoreboard
  import pipe_scoreboard_pkg::*;
#(
  parameter  int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter  int NUM_STAGES = 3,
  parameter  int FWD_EN     = 1,
  parameter  int LOAD_LAT   = 1,
  parameter  int CNT_W      = 32,
  localparam int SEL_W      = sel_w(NUM_STAGES)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwd_sel_rs1,
  output logic [SEL_W-1:0]      fwd_sel_rs2,
  output logic                  issue,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt
);

  slot_t [NUM_STAGES-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]       stall_cnt_q, fwd_cnt_q;

  logic             hit1, hit2, ld1, ld2, haz1, haz2;
  logic [SEL_W-1:0] m1, m2;

  sb_match #(.NUM_STAGES(NUM_STAGES), .M_W(SEL_W)) u_match_rs1 (
    .slots_i   (slot_q),
    .rs_i      (RD_W_MAX'(id_rs1)),
    .en_i      (id_rs1_used && (id_rs1 != '0)),
    .hit_o     (hit1),
    .m_o       (m1),
    .is_load_o (ld1)
  );

  sb_match #(.NUM_STAGES(NUM_STAGES), .M_W(SEL_W)) u_match_rs2 (
    .slots_i   (slot_q),
    .rs_i      (RD_W_MAX'(id_rs2)),
    .en_i      (id_rs2_used && (id_rs2 != '0)),
    .hit_o     (hit2),
    .m_o       (m2),
    .is_load_o (ld2)
  );

  // Without bypassing any in-flight producer blocks; with it, only a load that is still too young.
  assign haz1 = hit1 && ((FWD_EN == 0) || (ld1 && (int'(m1) < LOAD_LAT)));
  assign haz2 = hit2 && ((FWD_EN == 0) || (ld2 && (int'(m2) < LOAD_LAT)));

  assign fwd_sel_rs1 = ((FWD_EN != 0) && hit1 && !haz1) ? (m1 + SEL_W'(1)) : SEL_W'(FWD_RF);
  assign fwd_sel_rs2 = ((FWD_EN != 0) && hit2 && !haz2) ? (m2 + SEL_W'(1)) : SEL_W'(FWD_RF);

  // Flush wins over stall so a killed ID instruction never holds the front end.
  assign stall = id_valid && !flush && (haz1 || haz2);
  assign issue = id_valid && !stall && !flush;

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;

  // Next slot vector: new tag enters EX (bubble unless a real write issues), everything else ages by one.
  always_comb begin
    slot_d[0].valid   = issue && id_reg_write && (id_rd != '0);
    slot_d[0].rd      = RD_W_MAX'(id_rd);
    slot_d[0].is_load = id_is_load;
    for (int k = 1; k < NUM_STAGES; k++) begin
      slot_d[k] = slot_q[k-1];
    end
  end

  // Slot shift register; async clear discards all in-flight tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  // Saturating performance counters: stalled cycles and issued instructions that used a bypass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (issue && ((fwd_sel_rs1 != '0) || (fwd_sel_rs2 != '0)) && (fwd_cnt_q != '1)) begin
        fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_scoreboard.sv
// tb/tb_pipe_scoreboard.sv - randomized model-checked bench over three scoreboard configurations
module tb_pipe_scoreboard;

  typedef struct {
    bit v;
    int rd;
    bit ld;
  } ent_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;

  logic        stall_a, issue_a, stall_b, issue_b, stall_c, issue_c;
  logic [1:0]  s1_a, s2_a, s1_b, s2_b;
  logic [2:0]  s1_c, s2_c;
  logic [31:0] sc_a, fc_a;
  logic [3:0]  sc_b, fc_b, sc_c, fc_c;

  logic        st[3], iss[3];
  logic [2:0]  s1[3], s2[3];
  logic [31:0] sc[3], fc[3];

  int    NS[3]   = '{3, 3, 4};
  int    FWD[3]  = '{1, 0, 1};
  int    LL[3]   = '{1, 1, 2};
  longint CMAX[3] = '{64'hFFFF_FFFF, 15, 15};

  ent_t   hist[3][8];
  int     hlen[3];
  longint e_sc[3], e_fc[3];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pipe_scoreboard #(.NUM_STAGES(3), .FWD_EN(1), .LOAD_LAT(1), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_a), .fwd_sel_rs1(s1_a), .fwd_sel_rs2(s2_a), .issue(issue_a),
    .stall_cnt(sc_a), .fwd_cnt(fc_a));

  pipe_scoreboard #(.NUM_STAGES(3), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_b), .fwd_sel_rs1(s1_b), .fwd_sel_rs2(s2_b), .issue(issue_b),
    .stall_cnt(sc_b), .fwd_cnt(fc_b));

  pipe_scoreboard #(.NUM_STAGES(4), .FWD_EN(1), .LOAD_LAT(2), .CNT_W(4)) dut_c (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .stall(stall_c), .fwd_sel_rs1(s1_c), .fwd_sel_rs2(s2_c), .issue(issue_c),
    .stall_cnt(sc_c), .fwd_cnt(fc_c));

  assign st[0] = stall_a;  assign st[1] = stall_b;  assign st[2] = stall_c;
  assign iss[0] = issue_a; assign iss[1] = issue_b; assign iss[2] = issue_c;
  assign s1[0] = {1'b0, s1_a}; assign s1[1] = {1'b0, s1_b}; assign s1[2] = s1_c;
  assign s2[0] = {1'b0, s2_a}; assign s2[1] = {1'b0, s2_b}; assign s2[2] = s2_c;
  assign sc[0] = sc_a; assign sc[1] = {28'b0, sc_b}; assign sc[2] = {28'b0, sc_c};
  assign fc[0] = fc_a; assign fc[1] = {28'b0, fc_b}; assign fc[2] = {28'b0, fc_c};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: search the age-ordered list of recent issues for the youngest writer of rs.
  function automatic void eval(input int d, input int rs, input bit used,
                               output bit haz, output int sel);
    haz = 1'b0;
    sel = 0;
    if (!used || rs == 0) return;
    for (int k = 0; k < hlen[d]; k++) begin
      if (hist[d][k].v && hist[d][k].rd == rs) begin
        if (FWD[d] == 0) haz = 1'b1;
        else if (hist[d][k].ld && k < LL[d]) haz = 1'b1;
        else sel = k + 1;
        return;
      end
    end
  endfunction

  task automatic cycle(input bit v, input int r1, input int r2, input bit u1, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit fl);
    ent_t nxt[3];
    bit   h1, h2, es, ei;
    int   e1, e2;
    id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rs1_used = u1; id_rs2_used = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_is_load = ld; flush = fl;
    #1;
    for (int d = 0; d < 3; d++) begin
      eval(d, r1, u1, h1, e1);
      eval(d, r2, u2, h2, e2);
      es = v && !fl && (h1 || h2);
      ei = v && !es && !fl;
      check($sformatf("d%0d stall", d), 32'(st[d]), 32'(es));
      check($sformatf("d%0d issue", d), 32'(iss[d]), 32'(ei));
      check($sformatf("d%0d sel1", d), 32'(s1[d]), 32'(e1));
      check($sformatf("d%0d sel2", d), 32'(s2[d]), 32'(e2));
      check($sformatf("d%0d stall_cnt", d), sc[d], 32'(e_sc[d]));
      check($sformatf("d%0d fwd_cnt", d), fc[d], 32'(e_fc[d]));
      if (es && e_sc[d] < CMAX[d]) e_sc[d]++;
      if (ei && (e1 != 0 || e2 != 0) && e_fc[d] < CMAX[d]) e_fc[d]++;
      nxt[d].v  = ei && rw && (rd != 0);
      nxt[d].rd = rd;
      nxt[d].ld = ld;
    end
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
      hist[d][0] = nxt[d];
      if (hlen[d] < NS[d]) hlen[d]++;
    end
    @(negedge clk);
  endtask

  // Drop reset between edges, check the immediate effect, hold across one edge, release.
  task automatic do_reset();
    id_valid = 1'b1; flush = 1'b0; id_rs1_used = 1'b1; id_rs2_used = 1'b1;
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      check($sformatf("d%0d rst stall", d), 32'(st[d]), 32'd0);
      check($sformatf("d%0d rst issue", d), 32'(iss[d]), 32'd1);
      check($sformatf("d%0d rst sel1", d), 32'(s1[d]), 32'd0);
      check($sformatf("d%0d rst sel2", d), 32'(s2[d]), 32'd0);
      check($sformatf("d%0d rst stall_cnt", d), sc[d], 32'd0);
      check($sformatf("d%0d rst fwd_cnt", d), fc[d], 32'd0);
      hlen[d] = 0; e_sc[d] = 0; e_fc[d] = 0;
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_reg_write = 0; id_is_load = 0; flush = 0;
    for (int d = 0; d < 3; d++) begin hlen[d] = 0; e_sc[d] = 0; e_fc[d] = 0; end
    @(negedge clk);
    do_reset();

    // back-to-back ALU RAW, then a reader two cycles later
    cycle(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cycle(1, 5, 5, 1, 1, 6, 1, 0, 0);
    cycle(1, 5, 0, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use: stall then forward
    cycle(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cycle(1, 7, 0, 1, 0, 8, 1, 0, 0);
    cycle(1, 7, 0, 1, 0, 8, 1, 0, 0);
    cycle(1, 7, 0, 1, 0, 8, 1, 0, 0);
    cycle(1, 7, 0, 1, 0, 8, 1, 0, 0);
    // flush during a load-use stall
    cycle(1, 0, 0, 0, 0, 7, 1, 1, 0);
    cycle(1, 7, 0, 1, 0, 8, 1, 0, 1);
    cycle(1, 7, 0, 1, 0, 8, 1, 0, 0);
    // x0 writer/reader, then youngest of two x9 writers
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 9, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 9, 1, 0, 0);
    cycle(1, 9, 9, 1, 1, 0, 0, 0, 0);
    cycle(1, 9, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 9, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 9, 0, 1, 0, 0, 0, 0, 0);
    // reset with writers in flight, then a reader of the old rd
    cycle(1, 0, 0, 0, 0, 3, 1, 0, 0);
    cycle(1, 0, 0, 0, 0, 3, 1, 1, 0);
    cycle(1, 0, 0, 0, 0, 3, 1, 0, 0);
    do_reset();
    cycle(1, 3, 3, 1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) do_reset();
      cycle(($urandom % 8) != 0, $urandom % 4, $urandom % 4, ($urandom % 4) != 0,
            ($urandom % 2) != 0, $urandom % 4, ($urandom % 4) != 0, ($urandom % 3) == 0,
            ($urandom % 10) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scoreboard.md
Name: pipe_scoreboard

Overview:
Parametrised hazard scoreboard for the in-order RV32I pipeline. It tracks every in-flight register write from EX through WB in a shift register of destination tags. It generates the ID-stage stall and per-operand forwarding selects, and handles branch flush. It also keeps saturating stall and forward performance counters. It sits beside the ID/EX register and replaces ad-hoc hazard wiring, so the pipeline can be deepened or run with forwarding disabled.

Parameters:
REG_ADDR_W, 5, register index width (x0 hardwired zero).
NUM_STAGES, 3, in-flight slots tracked after ID (slot 0 = EX … slot NUM_STAGES-1 = WB); legal 2..8.
FWD_EN, 1, 1 = bypass network present; 0 = stall until writeback completes.
LOAD_LAT, 1, slots a load must advance past before its data is forwardable; legal 0..NUM_STAGES-1.
CNT_W, 32, performance counter width.

Ports:
clk  input  1  pipeline clock, rising edge.
reset  input  1  asynchronous, active-low reset.
id_valid  input  1  ID holds a real instruction.
id_rs1  input  REG_ADDR_W  source 1 index.
id_rs2  input  REG_ADDR_W  source 2 index.
id_rs1_used  input  1  instruction reads rs1.
id_rs2_used  input  1  instruction reads rs2.
id_rd  input  REG_ADDR_W  destination index.
id_reg_write  input  1  instruction writes rd.
id_is_load  input  1  instruction is a load.
flush  input  1  branch/jump taken in EX: kill the instruction in ID.
stall  output  1  hold PC and IF/ID; inject a bubble into ID/EX.
fwd_sel_rs1  output  SEL_W  0 = regfile, k+1 = forward from slot k; SEL_W = $clog2(NUM_STAGES+1).
fwd_sel_rs2  output  SEL_W  same encoding for rs2.
issue  output  1  ID instruction enters EX this cycle.
stall_cnt  output  CNT_W  cycles with stall=1, saturating.
fwd_cnt  output  CNT_W  issued instructions using ≥1 forward, saturating.

Behaviour:
- State: slot[k] = {valid, rd, is_load}, k = 0..NUM_STAGES-1. All outputs are combinational from slot state plus ID inputs, so there is zero cycle latency to the ID decision.
- issue = id_valid & ~stall & ~flush.
- Every clock:
  - slot[k+1] <= slot[k].
  - slot[NUM_STAGES-1] is discarded.
  - slot[0] <= {issue & id_reg_write & (id_rd!=0), id_rd, id_is_load}; otherwise a bubble (valid=0).
- Operand match, per used source with index != 0:
  - m = smallest k with slot[k].valid & slot[k].rd == rs; the youngest producer wins.
  - Sources with index 0 or not used never match; fwd_sel = 0.
- FWD_EN=1:
  - Matching load with m < LOAD_LAT: hazard; stall=1, fwd_sel=0.
  - Otherwise fwd_sel = m+1; no match gives 0.
- FWD_EN=0: any match in any slot is a hazard; fwd_sel is held at 0.
- stall = id_valid & ~flush & (hazard_rs1 | hazard_rs2).
- flush has priority over stall: stall=0, issue=0, slot[0] gets a bubble. Older slots shift normally, so the branch itself completes.
- Counters:
  - stall_cnt increments when stall=1.
  - fwd_cnt increments when issue=1 and either fwd_sel != 0.
  - Both saturate at all-ones and never wrap.
- Asynchronous reset (reset=0):
  - All slots are invalid and both counters are 0.
  - Outputs go to stall=0, issue=id_valid, fwd_sel=0 immediately, including mid-operation; state is cleared with no partial shift.
- Reset release is synchronous in effect: the first shift happens on the first rising edge with reset=1.
- id_valid=0: stall=0, issue=0, bubble inserted; slot state still shifts.

Decomposition:
- Shared package: REG_ADDR_W default, fwd_sel encoding constants (FWD_RF=0), slot struct typedef {valid, rd, is_load}, SEL_W function.
- One natural sub-module, sb_match: a priority matcher taking the slot vector and one source index, returning {hit, m, is_load}. It is instantiated twice, for rs1 and rs2.
- Counters stay inline.

Test Plan:
- Back-to-back ALU RAW: issue addi x5 (rd=5, write), then add x6,x5,x5 next cycle -> stall=0, fwd_sel_rs1=fwd_sel_rs2=1. A third instruction reading x5 two cycles after the addi -> fwd_sel=2.
- Load-use, LOAD_LAT=1: lw x7, then immediately an instruction with rs1=7 -> stall=1 for exactly 1 cycle, stall_cnt=1. Next cycle fwd_sel_rs1=2 and issue=1.
- FWD_EN=0, NUM_STAGES=3: add x3 followed by a reader of x3 -> stall=1 for 3 cycles, then issue with fwd_sel=0, stall_cnt=3.
- x0 and priority: a writer to x0 followed by a reader of x0 -> no stall, fwd_sel=0. Two writers of x9 in consecutive cycles followed by a reader -> fwd_sel=1 (youngest producer).
- flush during stall: load-use stall active and flush=1 the same cycle -> stall=0, issue=0. slot[0] is invalid next cycle, and the load still advances to slot 1.
- Async reset mid-stream: with 3 valid slots, drop reset between clock edges -> stall and fwd_sel are 0 immediately and counters read 0. After release, a reader of the old rd -> no stall.
